// File: rtl/regfile_sb.sv
// Register file with per-register in-flight-writer scoreboard and issue stall.
// Optional macro REGFILE_BYPASS_EN adds a writeback-to-read bypass and same-cycle release of busy sources.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int CNT_W  = 2,
    localparam int REG_NUM = 1 << AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  issue_valid,
    input  logic [NRD*AW-1:0]     issue_src,
    input  logic [NRD-1:0]        issue_src_v,
    input  logic                  issue_wr,
    input  logic [AW-1:0]         issue_dest,
    output logic                  stall,
    output logic [REG_NUM-1:0]    busy_vec,
    output logic                  sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [REG_NUM];
    logic [CNT_W-1:0]  cnt  [REG_NUM];

    logic [NRD-1:0]     src_busy;
    logic               dest_full;
    logic               accept;
    logic               err_set;
    logic               wr_valid;
    logic [REG_NUM-1:0] inc_vec;
    logic [REG_NUM-1:0] wr_vec;

    assign wr_valid = we && (waddr != '0);

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic [AW-1:0]     ra;
        logic [AW-1:0]     sa;
        logic [DATA_W-1:0] arr_val;
        logic              rel;

        assign ra      = raddr[i*AW +: AW];
        assign sa      = issue_src[i*AW +: AW];
        assign arr_val = (ra == '0) ? '0 : regs[ra];
`ifdef REGFILE_BYPASS_EN
        assign rdata[i*DATA_W +: DATA_W] = (wr_valid && waddr == ra) ? wdata : arr_val;
        // The last outstanding writer retiring now makes the operand forwardable.
        assign rel = wr_valid && (waddr == sa) && (cnt[sa] == CNT_ONE);
`else
        assign rdata[i*DATA_W +: DATA_W] = arr_val;
        assign rel = 1'b0;
`endif
        assign src_busy[i] = issue_src_v[i] && (sa != '0) && (cnt[sa] != '0) && !rel;
    end

    assign dest_full = issue_wr && (issue_dest != '0) && (cnt[issue_dest] == CNT_MAX)
                       && !(we && waddr == issue_dest);
    assign stall     = issue_valid && ((|src_busy) || dest_full);
    assign accept    = issue_valid && !stall;

    // An issue to the same register as an unexpected writeback absorbs the error.
    assign err_set = wr_valid && (cnt[waddr] == '0)
                     && !(accept && issue_wr && issue_dest == waddr);

    always_comb begin
        inc_vec = '0;
        wr_vec  = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            inc_vec[r] = accept && issue_wr && (issue_dest == AW'(r));
            wr_vec[r]  = we && (waddr == AW'(r));
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < REG_NUM; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (wr_valid) begin
                regs[waddr] <= wdata;
            end
            if (err_set) begin
                sb_err <= 1'b1;
            end
            for (int r = 1; r < REG_NUM; r++) begin
                if (inc_vec[r] && !wr_vec[r]) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (!inc_vec[r] && wr_vec[r] && cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Table-driven bench for regfile_sb at default parameters; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        issue_valid;
    logic [9:0]  issue_src;
    logic [1:0]  issue_src_v;
    logic        issue_wr;
    logic [4:0]  issue_dest;
    logic        stall;
    logic [31:0] busy_vec;
    logic        sb_err;

    regfile_sb dut (
        .clk         (clk),
        .reset       (reset),
        .raddr       (raddr),
        .rdata       (rdata),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .issue_valid (issue_valid),
        .issue_src   (issue_src),
        .issue_src_v (issue_src_v),
        .issue_wr    (issue_wr),
        .issue_dest  (issue_dest),
        .stall       (stall),
        .busy_vec    (busy_vec),
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        iv;
        logic [4:0]  s0;
        logic [4:0]  s1;
        logic [1:0]  sv;
        logic        iw;
        logic [4:0]  dest;
        logic        x_stall;
        logic [31:0] x_rd0;
        logic [31:0] x_rd1;
        logic [31:0] x_busy;
        logic        x_err;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic iv, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] sv, input logic iw, input logic [4:0] dest,
                       input logic xs, input logic [31:0] xr0, input logic [31:0] xr1,
                       input logic [31:0] xb, input logic xe);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.ra0 = ra0; v.ra1 = ra1;
        v.iv = iv; v.s0 = s0; v.s1 = s1; v.sv = sv; v.iw = iw; v.dest = dest;
        v.x_stall = xs; v.x_rd0 = xr0; v.x_rd1 = xr1; v.x_busy = xb; v.x_err = xe;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        issue_valid = 1'b0; issue_src = '0; issue_src_v = '0; issue_wr = 1'b0; issue_dest = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        //   we wa  wd            ra0 ra1 iv s0 s1 sv     iw dest stall           rd0                   rd1        busy         err
        add(0, 0, 32'h0,         5,  0,  0, 0, 0, 2'b00, 0, 0,   0,              32'h0,                32'h0,     32'h0,       0);
        add(1, 0, 32'hDEAD,      0,  0,  1, 0, 0, 2'b00, 1, 0,   0,              32'h0,                32'h0,     32'h0,       0);
        add(0, 0, 32'h0,         0,  0,  1, 0, 0, 2'b00, 1, 3,   0,              32'h0,                32'h0,     32'h8,       0);
        add(1, 3, 32'h7,         3,  0,  1, 3, 0, 2'b01, 0, 0,   !BYP,           BYP ? 32'h7 : 32'h0,  32'h0,     32'h0,       0);
        add(0, 0, 32'h0,         3,  0,  1, 3, 0, 2'b01, 0, 0,   0,              32'h7,                32'h0,     32'h0,       0);
        add(0, 0, 32'h0,         0,  0,  1, 0, 0, 2'b00, 1, 4,   0,              32'h0,                32'h0,     32'h10,      0);
        add(0, 0, 32'h0,         0,  0,  1, 0, 0, 2'b00, 1, 4,   0,              32'h0,                32'h0,     32'h10,      0);
        add(0, 0, 32'h0,         0,  0,  1, 0, 0, 2'b00, 1, 4,   0,              32'h0,                32'h0,     32'h10,      0);
        add(0, 0, 32'h0,         0,  0,  1, 0, 0, 2'b00, 1, 4,   1,              32'h0,                32'h0,     32'h10,      0);
        add(1, 4, 32'h44,        4,  0,  1, 0, 0, 2'b00, 1, 4,   0,              BYP ? 32'h44 : 32'h0, 32'h0,     32'h10,      0);
        add(1, 4, 32'h45,        4,  0,  0, 0, 0, 2'b00, 0, 0,   0,              BYP ? 32'h45 : 32'h44,32'h0,     32'h10,      0);
        add(1, 9, 32'h99,        0,  0,  1, 4, 0, 2'b01, 0, 0,   1,              32'h0,                32'h0,     32'h10,      1);
        add(0, 0, 32'h0,         9,  4,  1, 0, 0, 2'b00, 1, 6,   0,              32'h99,               32'h45,    32'h50,      1);
        add(1, 6, 32'h66,        0,  0,  1, 0, 0, 2'b00, 1, 6,   0,              32'h0,                32'h0,     32'h50,      1);
        add(0, 0, 32'h0,         6,  0,  1, 4, 6, 2'b00, 0, 0,   0,              32'h66,               32'h0,     32'h50,      1);
        add(0, 0, 32'h0,         0,  0,  1, 0, 6, 2'b10, 0, 0,   1,              32'h0,                32'h0,     32'h50,      1);
        add(1, 5, 32'h55,        0,  0,  0, 4, 0, 2'b01, 1, 4,   0,              32'h0,                32'h0,     32'h50,      1);

        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < vq.size(); k++) begin
            we = vq[k].we; waddr = vq[k].wa; wdata = vq[k].wd;
            raddr = {vq[k].ra1, vq[k].ra0};
            issue_valid = vq[k].iv; issue_src = {vq[k].s1, vq[k].s0};
            issue_src_v = vq[k].sv; issue_wr = vq[k].iw; issue_dest = vq[k].dest;
            #1;
            chk($sformatf("v%0d stall", k), 32'(stall), 32'(vq[k].x_stall));
            chk($sformatf("v%0d rdata0", k), rdata[31:0], vq[k].x_rd0);
            chk($sformatf("v%0d rdata1", k), rdata[63:32], vq[k].x_rd1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d busy_vec", k), busy_vec, vq[k].x_busy);
            chk($sformatf("v%0d sb_err", k), 32'(sb_err), 32'(vq[k].x_err));
            @(negedge clk);
        end

        // Reset asserted mid-cycle with registers 4 and 6 still in flight.
        idle_inputs();
        raddr = 10'd5;
        #1;
        chk("pre-reset rdata0", rdata[31:0], 32'h55);
        issue_valid = 1'b1; issue_src = 10'd4; issue_src_v = 2'b01;
        #1;
        chk("pre-reset stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("reset rdata0", rdata[31:0], 32'h0);
        chk("reset busy_vec", busy_vec, 32'h0);
        chk("reset sb_err", 32'(sb_err), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Issue and writeback to the same idle register in one cycle: no error, stays idle.
        idle_inputs();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 5'd7;
        we = 1'b1; waddr = 5'd7; wdata = 32'h77;
        @(posedge clk);
        #1;
        chk("same-cycle busy_vec", busy_vec, 32'h0);
        chk("same-cycle sb_err", 32'(sb_err), 32'd0);
        @(negedge clk);
        idle_inputs();
        raddr = 10'd7;
        #1;
        chk("same-cycle rdata0", rdata[31:0], 32'h77);

        // Writeback from an instruction whose scoreboard entry the reset discarded.
        we = 1'b1; waddr = 5'd4; wdata = 32'h4444;
        @(posedge clk);
        #1;
        chk("stale-wb sb_err", 32'(sb_err), 32'd1);
        chk("stale-wb busy_vec", busy_vec, 32'h0);
        @(negedge clk);
        idle_inputs();
        raddr = 10'd4;
        #1;
        chk("stale-wb rdata0", rdata[31:0], 32'h4444);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
